// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered operand-issue stage feeding alu.
// Builds ALU operands a/b and passes aluc/dest through a 2-entry skid buffer
// with a valid/ready handshake. in_ready comes straight from a register.
// Optional feature macro: ALU_ISSUE_FWD_EN (operand forwarding at accept).
module alu_issue_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_aluc,
  input  logic [1:0]           in_src_a_sel,
  input  logic [1:0]           in_src_b_sel,
  input  logic [DATA_W-1:0]    in_rs_val,
  input  logic [DATA_W-1:0]    in_rt_val,
  input  logic [15:0]          in_imm,
  input  logic [4:0]           in_shamt,
  input  logic [REG_IDX_W-1:0] in_dest,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [REG_IDX_W-1:0] in_rs_idx,
  input  logic [REG_IDX_W-1:0] in_rt_idx,
  input  logic                 fwd_valid,
  input  logic [REG_IDX_W-1:0] fwd_dest,
  input  logic [DATA_W-1:0]    fwd_data,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_a,
  output logic [DATA_W-1:0]    out_b,
  output logic [5:0]           out_aluc,
  output logic [REG_IDX_W-1:0] out_dest,
  output logic                 out_illegal
);

  logic                 skid_valid;
  logic [DATA_W-1:0]    skid_a;
  logic [DATA_W-1:0]    skid_b;
  logic [5:0]           skid_aluc;
  logic [REG_IDX_W-1:0] skid_dest;
  logic                 skid_illegal;

  logic [DATA_W-1:0]    rs_eff;
  logic [DATA_W-1:0]    rt_eff;
  logic [DATA_W-1:0]    new_a;
  logic [DATA_W-1:0]    new_b;
  logic                 new_illegal;
  logic                 accept;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  // Source register values, optionally replaced by the forwarding bus
`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    rs_eff = in_rs_val;
    rt_eff = in_rt_val;
    if (fwd_valid && (fwd_dest == in_rs_idx) && (in_rs_idx != '0))
      rs_eff = fwd_data;
    if (fwd_valid && (fwd_dest == in_rt_idx) && (in_rt_idx != '0))
      rt_eff = fwd_data;
  end
`else
  always_comb begin
    rs_eff = in_rs_val;
    rt_eff = in_rt_val;
  end
`endif

  // Operand selection for a and b
  always_comb begin
    new_a = '0;
    new_b = '0;
    case (in_src_a_sel)
      2'd0:    new_a = rs_eff;
      2'd1:    new_a = {{(DATA_W-5){1'b0}}, in_shamt};
      2'd2:    new_a = {{(DATA_W-16){1'b0}}, in_imm};
      default: new_a = '0;
    endcase
    case (in_src_b_sel)
      2'd0:    new_b = rt_eff;
      2'd1:    new_b = {{(DATA_W-16){in_imm[15]}}, in_imm};
      2'd2:    new_b = {{(DATA_W-16){1'b0}}, in_imm};
      default: new_b = '0;
    endcase
  end

  // Classify aluc against the set of operations alu implements
  always_comb begin
    new_illegal = 1'b1;
    case (in_aluc)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h0F:   new_illegal = 1'b0;
      default: new_illegal = 1'b1;
    endcase
  end

  // Output/skid register update: flush clears valids, skid drains before new accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_aluc     <= '0;
      out_dest     <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_aluc    <= '0;
      skid_dest    <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so only the skid-to-output move can happen
      if (out_ready) begin
        out_a       <= skid_a;
        out_b       <= skid_b;
        out_aluc    <= skid_aluc;
        out_dest    <= skid_dest;
        out_illegal <= skid_illegal;
        out_valid   <= 1'b1;
        skid_valid  <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_a       <= new_a;
        out_b       <= new_b;
        out_aluc    <= in_aluc;
        out_dest    <= in_dest;
        out_illegal <= new_illegal;
        out_valid   <= 1'b1;
      end else begin
        skid_a       <= new_a;
        skid_b       <= new_b;
        skid_aluc    <= in_aluc;
        skid_dest    <= in_dest;
        skid_illegal <= new_illegal;
        skid_valid   <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// back-pressure/flush sequences and randomized traffic against a queue model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [5:0]  in_aluc, out_aluc;
  logic [1:0]  in_src_a_sel, in_src_b_sel;
  logic [31:0] in_rs_val, in_rt_val, out_a, out_b;
  logic [15:0] in_imm;
  logic [4:0]  in_shamt, in_dest, out_dest;
  logic [4:0]  in_rs_idx, in_rt_idx, fwd_dest;
  logic        fwd_valid;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .REG_IDX_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluc(in_aluc), .in_src_a_sel(in_src_a_sel), .in_src_b_sel(in_src_b_sel),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_shamt(in_shamt), .in_dest(in_dest),
`ifdef ALU_ISSUE_FWD_EN
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .fwd_valid(fwd_valid),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_aluc(out_aluc),
    .out_dest(out_dest), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  dest;
    logic        ill;
  } ent_t;

  ent_t q[$];

  typedef struct {
    logic [5:0]  aluc;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what decode currently presents, built from the operand rules
  function automatic ent_t build_entry();
    ent_t e;
    logic [31:0] rs, rt;
    rs = in_rs_val;
    rt = in_rt_val;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_valid && fwd_dest == in_rs_idx && in_rs_idx != 0) rs = fwd_data;
    if (fwd_valid && fwd_dest == in_rt_idx && in_rt_idx != 0) rt = fwd_data;
`endif
    case (in_src_a_sel)
      2'd0: e.a = rs;
      2'd1: e.a = 32'(in_shamt);
      2'd2: e.a = 32'(in_imm);
      default: e.a = 0;
    endcase
    case (in_src_b_sel)
      2'd0: e.b = rt;
      2'd1: e.b = 32'($signed(in_imm));
      2'd2: e.b = 32'(in_imm);
      default: e.b = 0;
    endcase
    e.aluc = in_aluc;
    e.dest = in_dest;
    e.ill = !(in_aluc inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04,
                              6'h06, 6'h07, 6'h0F});
    return e;
  endfunction

  // Model the 2-deep FIFO across one clock edge using the current inputs
  task automatic model_update();
    ent_t e;
    bit   acc;
    if (rst || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      e = build_entry();
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_aluc", 32'(out_aluc), 32'(q[0].aluc));
      chk("out_dest", 32'(out_dest), 32'(q[0].dest));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_op(input logic [5:0] aluc, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input logic [4:0] shamt, input logic [4:0] dest);
    in_aluc = aluc; in_src_a_sel = asel; in_src_b_sel = bsel;
    in_rs_val = rs; in_rt_val = rt; in_imm = imm; in_shamt = shamt; in_dest = dest;
  endtask

  initial begin
    vecs[0]  = '{6'h20, 2'd0, 2'd1, 32'h5,        32'h0,  16'hFFFF, 5'd0, 32'h5,        32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{6'h00, 2'd1, 2'd0, 32'hDEAD,     32'h10, 16'h0,    5'd7, 32'h7,        32'h10,       1'b0};
    vecs[2]  = '{6'h0F, 2'd2, 2'd3, 32'h99,       32'h77, 16'h1234, 5'd3, 32'h1234,     32'h0,        1'b0};
    vecs[3]  = '{6'h25, 2'd0, 2'd2, 32'hF0F0,     32'h1,  16'h8001, 5'd0, 32'hF0F0,     32'h00008001, 1'b0};
    vecs[4]  = '{6'h22, 2'd0, 2'd0, 32'hA,        32'h3,  16'h0,    5'd0, 32'hA,        32'h3,        1'b0};
    vecs[5]  = '{6'h2A, 2'd0, 2'd1, 32'h80000000, 32'h0,  16'h7FFF, 5'd0, 32'h80000000, 32'h00007FFF, 1'b0};
    vecs[6]  = '{6'h3F, 2'd3, 2'd3, 32'h1,        32'h2,  16'h5555, 5'd9, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{6'h01, 2'd1, 2'd1, 32'h0,        32'h0,  16'h8000, 5'd31, 32'h1F,      32'hFFFF8000, 1'b1};
    vecs[8]  = '{6'h2B, 2'd2, 2'd2, 32'h0,        32'h0,  16'hFFFF, 5'd0, 32'h0000FFFF, 32'h0000FFFF, 1'b0};
    vecs[9]  = '{6'h07, 2'd1, 2'd0, 32'h0,        32'hCAFEBABE, 16'h0, 5'd1, 32'h1,     32'hCAFEBABE, 1'b0};
    vecs[10] = '{6'h28, 2'd0, 2'd0, 32'h12345678, 32'h9,  16'h0,    5'd0, 32'h12345678, 32'h9,        1'b1};
    vecs[11] = '{6'h04, 2'd3, 2'd1, 32'hFFFF,     32'h0,  16'h0001, 5'd0, 32'h0,        32'h1,        1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_rs_idx = 0; in_rt_idx = 0; fwd_valid = 1'b0; fwd_dest = 0; fwd_data = 0;
    set_op(6'h20, 2'd0, 2'd0, 32'h11, 32'h22, 16'h0, 5'd0, 5'd4);

    // Reset held two cycles with in_valid high
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_a", out_a, 32'h0);
    chk("rst_out_b", out_b, 32'h0);
    chk("rst_out_aluc", 32'(out_aluc), 32'h0);
    chk("rst_out_dest", 32'(out_dest), 32'h0);
    chk("rst_out_illegal", 32'(out_illegal), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    // Directed operand vectors, one at a time through an empty buffer
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_op(vecs[i].aluc, vecs[i].asel, vecs[i].bsel, vecs[i].rs, vecs[i].rt,
             vecs[i].imm, vecs[i].shamt, 5'(i + 1));
      in_valid = 1'b1;
      tick();
      chk("vec_valid", 32'(out_valid), 32'h1);
      chk("vec_a", out_a, vecs[i].exp_a);
      chk("vec_b", out_b, vecs[i].exp_b);
      chk("vec_ill", 32'(out_illegal), 32'(vecs[i].exp_ill));
      in_valid = 1'b0;
      tick();
      chk("vec_drop", 32'(out_valid), 32'h0);
    end

    // Back-pressure: three pushes, two held, then ordered drain
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(6'h21, 2'd0, 2'd3, 32'h101, 32'h0, 16'h0, 5'd0, 5'd1); tick();
    set_op(6'h21, 2'd0, 2'd3, 32'h102, 32'h0, 16'h0, 5'd0, 5'd2); tick();
    set_op(6'h21, 2'd0, 2'd3, 32'h103, 32'h0, 16'h0, 5'd0, 5'd3); tick();
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    chk("bp_hold_a", out_a, 32'h101);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_drain1_a", out_a, 32'h102);
    chk("bp_drain1_rdy", 32'(in_ready), 32'h1);
    tick();
    chk("bp_drain2_valid", 32'(out_valid), 32'h0);

    // Flush with two buffered entries and a simultaneous push
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(6'h20, 2'd0, 2'd3, 32'h1, 32'h0, 16'h0, 5'd0, 5'd1); tick();
    set_op(6'h20, 2'd0, 2'd3, 32'h2, 32'h0, 16'h0, 5'd0, 5'd2); tick();
    set_op(6'h20, 2'd0, 2'd3, 32'h3, 32'h0, 16'h0, 5'd0, 5'd3);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_lost", 32'(out_valid), 32'h0);

`ifdef ALU_ISSUE_FWD_EN
    // Forwarding replaces rs only when the index matches and is nonzero
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(6'h20, 2'd0, 2'd0, 32'h5, 32'h6, 16'h0, 5'd0, 5'd1);
    in_rs_idx = 5'd3; in_rt_idx = 5'd4; fwd_valid = 1'b1; fwd_dest = 5'd3; fwd_data = 32'hAA;
    tick();
    chk("fwd_a", out_a, 32'hAA);
    chk("fwd_b", out_b, 32'h6);
    in_rs_idx = 5'd0; fwd_dest = 5'd0;
    tick();
    chk("fwd_zero_a", out_a, 32'h5);
    in_valid = 1'b0; fwd_valid = 1'b0;
    tick();
`endif

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      set_op(6'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom,
             16'($urandom), 5'($urandom), 5'($urandom));
      in_rs_idx = 5'($urandom_range(0, 3));
      in_rt_idx = 5'($urandom_range(0, 3));
      fwd_valid = $urandom_range(0, 1);
      fwd_dest  = 5'($urandom_range(0, 3));
      fwd_data  = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
